// File: rtl/store_unit_if.sv
// Data-memory write port between the store controller (master) and memory (slave).
interface store_unit_if;
    logic        dmem_req_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic        dmem_ack_i;

    modport master (
        output dmem_req_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        input  dmem_ack_i
    );

    modport slave (
        input  dmem_req_o, dmem_addr_o, dmem_wdata_o, dmem_be_o,
        output dmem_ack_i
    );
endinterface

// File: rtl/store_unit.sv
// RV32 store controller: SB/SH/SW lane generation, req/ack to data memory with timeout.
// Define STORE_MISALIGN_TRAP_EN to fault misaligned SH/SW with cause 01 instead of writing.
module store_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    output logic        stall_o,
    output logic        done_o,
    output logic        fault_o,
    output logic [1:0]  fault_cause_o,
    store_unit_if.master dmem
);
    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        done_q, done_d;
    logic        fault_q, fault_d;
    logic [1:0]  cause_q, cause_d;

    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic        illegal;
    logic        misaligned;

    always_comb begin
        lane_be    = 4'b0000;
        lane_wdata = 32'h0;
        illegal    = 1'b0;
        case (funct3_i)
            3'b000: begin
                lane_be    = 4'b0001 << addr_i[1:0];
                lane_wdata = {4{data_i[7:0]}};
            end
            3'b001: begin
                lane_be    = 4'b0011 << {addr_i[1], 1'b0};
                lane_wdata = {2{data_i[15:0]}};
            end
            3'b010: begin
                lane_be    = 4'b1111;
                lane_wdata = data_i;
            end
            default: illegal = 1'b1;
        endcase
    end

`ifdef STORE_MISALIGN_TRAP_EN
    assign misaligned = ((funct3_i == 3'b001) && addr_i[0]) ||
                        ((funct3_i == 3'b010) && (addr_i[1:0] != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        done_d  = 1'b0;
        fault_d = 1'b0;
        cause_d = 2'b00;
        case (state_q)
            IDLE: begin
                if (mem_write_i) begin
                    addr_d  = {addr_i[31:2], 2'b00};
                    wdata_d = lane_wdata;
                    be_d    = lane_be;
                    if (illegal) begin
                        state_d = RESP;
                        fault_d = 1'b1;
                        cause_d = 2'b11;
                    end else if (misaligned) begin
                        state_d = RESP;
                        fault_d = 1'b1;
                        cause_d = 2'b01;
                    end else begin
                        state_d = REQ;
                        cnt_d   = 8'd0;
                    end
                end
            end
            REQ: begin
                // An ack arriving on the final counted cycle still commits the store.
                if (dmem.dmem_ack_i) begin
                    state_d = RESP;
                    done_d  = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = RESP;
                    fault_d = 1'b1;
                    cause_d = 2'b10;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            be_q    <= 4'b0000;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            cause_q <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            cause_q <= cause_d;
        end
    end

    assign stall_o       = ((state_q == IDLE) && mem_write_i) || (state_q == REQ);
    assign done_o        = done_q;
    assign fault_o       = fault_q;
    assign fault_cause_o = cause_q;

    // Bus fields are forced to zero whenever no request is outstanding.
    assign dmem.dmem_req_o   = (state_q == REQ);
    assign dmem.dmem_addr_o  = (state_q == REQ) ? addr_q  : 32'h0;
    assign dmem.dmem_wdata_o = (state_q == REQ) ? wdata_q : 32'h0;
    assign dmem.dmem_be_o    = (state_q == REQ) ? be_q    : 4'b0000;
endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed cases followed by random stores
// checked against an arithmetic model of lane generation and handshake timing.
module tb_store_unit;
    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] data = 32'h0;
    logic        stall, done, fault;
    logic [1:0]  cause;

    int n_total = 0;
    int n_pass  = 0;

    store_unit_if bus();

    store_unit #(.TIMEOUT(TMO)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .mem_write_i   (mem_write),
        .funct3_i      (funct3),
        .addr_i        (addr),
        .data_i        (data),
        .stall_o       (stall),
        .done_o        (done),
        .fault_o       (fault),
        .fault_cause_o (cause),
        .dmem          (bus.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_req"},   32'(bus.dmem_req_o),  32'd0);
        chk({tag, "_addr"},  bus.dmem_addr_o,      32'd0);
        chk({tag, "_wdata"}, bus.dmem_wdata_o,     32'd0);
        chk({tag, "_be"},    32'(bus.dmem_be_o),   32'd0);
        chk({tag, "_done"},  32'(done),            32'd0);
        chk({tag, "_fault"}, 32'(fault),           32'd0);
        chk({tag, "_cause"}, 32'(cause),           32'd0);
    endtask

    // One store from IDLE through RESP. ack_at = REQ cycle index that sees ack (>= TMO: never).
    task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] d, input int ack_at);
        logic        illegal, mis, nobus, acked;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_addr;
        logic [1:0]  exp_cause;
        int          nreq;
        illegal  = 1'b0;
        mis      = 1'b0;
        exp_be   = 4'd0;
        exp_wd   = 32'd0;
        exp_addr = a - (a % 4);
        case (f3)
            3'd0: begin
                exp_be = 4'(1 << (a % 4));
                exp_wd = {24'd0, d[7:0]} * 32'h0101_0101;
            end
            3'd1: begin
                exp_be = 4'(3 << (a & 2));
                exp_wd = {16'd0, d[15:0]} * 32'h0001_0001;
                mis    = (a % 2) != 0;
            end
            3'd2: begin
                exp_be = 4'd15;
                exp_wd = d;
                mis    = (a % 4) != 0;
            end
            default: illegal = 1'b1;
        endcase
`ifndef STORE_MISALIGN_TRAP_EN
        mis = 1'b0;
`endif
        nobus     = illegal || mis;
        exp_cause = illegal ? 2'd3 : 2'd1;
        acked     = ack_at < TMO;
        nreq      = acked ? ack_at + 1 : TMO;

        mem_write = 1'b1;
        funct3 = f3;
        addr = a;
        data = d;
        bus.dmem_ack_i = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "_idle_stall"}, 32'(stall), 32'd1);
        chk({tag, "_idle_req"}, 32'(bus.dmem_req_o), 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        bus.dmem_ack_i = 1'b0;
        if (nobus) begin
            chk({tag, "_nb_fault"}, 32'(fault), 32'd1);
            chk({tag, "_nb_cause"}, 32'(cause), 32'(exp_cause));
            chk({tag, "_nb_done"},  32'(done), 32'd0);
            chk({tag, "_nb_req"},   32'(bus.dmem_req_o), 32'd0);
            chk({tag, "_nb_stall"}, 32'(stall), 32'd0);
        end else begin
            for (int k = 0; k < nreq; k++) begin
                chk({tag, "_req"},   32'(bus.dmem_req_o), 32'd1);
                chk({tag, "_addr"},  bus.dmem_addr_o, exp_addr);
                chk({tag, "_be"},    32'(bus.dmem_be_o), 32'(exp_be));
                chk({tag, "_wdata"}, bus.dmem_wdata_o, exp_wd);
                chk({tag, "_stall"}, 32'(stall), 32'd1);
                chk({tag, "_early"}, 32'({done, fault}), 32'd0);
                mem_write = 1'($urandom_range(0, 1));
                bus.dmem_ack_i = (k == ack_at);
                @(negedge clk);
            end
            mem_write = 1'b0;
            bus.dmem_ack_i = 1'b0;
            chk({tag, "_done"},  32'(done), 32'(acked));
            chk({tag, "_fault"}, 32'(fault), 32'(!acked));
            chk({tag, "_cause"}, 32'(cause), acked ? 32'd0 : 32'd2);
            chk({tag, "_resp_req"}, 32'(bus.dmem_req_o), 32'd0);
            chk({tag, "_resp_be"},  32'(bus.dmem_be_o), 32'd0);
        end
        // Now in RESP: a pending request and stray ack must not stall or matter.
        mem_write = 1'b1;
        bus.dmem_ack_i = 1'($urandom_range(0, 1));
        #1;
        chk({tag, "_resp_stall"}, 32'(stall), 32'd0);
        @(negedge clk);
        mem_write = 1'b0;
        bus.dmem_ack_i = 1'b0;
    endtask

    initial begin
        bus.dmem_ack_i = 1'b0;
        repeat (2) @(negedge clk);
        chk_quiet("reset");
        chk("reset_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        do_store("sb_1003", 3'b000, 32'h0000_1003, 32'hAABB_CCDD, 0);
        do_store("sh_2002", 3'b001, 32'h0000_2002, 32'h0000_1234, 2);
        do_store("sw_3001", 3'b010, 32'h0000_3001, 32'hCAFE_F00D, 0);
        do_store("sh_odd",  3'b001, 32'h0000_5005, 32'h0000_BEEF, 1);
        do_store("illegal", 3'b011, 32'h0000_4000, 32'h1111_2222, 0);
        do_store("timeout", 3'b010, 32'h0000_6000, 32'h1234_5678, 99);
        do_store("ack_last",3'b010, 32'h0000_7000, 32'h8765_4321, TMO - 1);

        // Reset during the second REQ cycle.
        mem_write = 1'b1;
        funct3 = 3'b010;
        addr = 32'h0000_8000;
        data = 32'h5555_AAAA;
        @(negedge clk);
        mem_write = 1'b0;
        chk("rst_mid_req0", 32'(bus.dmem_req_o), 32'd1);
        @(negedge clk);
        chk("rst_mid_req1", 32'(bus.dmem_req_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk_quiet("rst_mid");
        chk("rst_mid_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk_quiet("rst_after");
        do_store("post_rst", 3'b000, 32'h0000_9002, 32'h0000_00A5, 1);

        for (int t = 0; t < 40; t++) begin
            logic [2:0] f3;
            int gap;
            f3  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                bus.dmem_ack_i = 1'($urandom_range(0, 1));
                #1;
                chk("gap_stall", 32'(stall), 32'd0);
                chk("gap_req", 32'(bus.dmem_req_o), 32'd0);
                @(negedge clk);
                chk("gap_pulse", 32'({done, fault}), 32'd0);
            end
            bus.dmem_ack_i = 1'b0;
            do_store("rnd", f3, $urandom, $urandom, $urandom_range(0, TMO + 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
